// File: rtl/program_loader_pkg.sv
// Shared types and sizing for the program loader: FSM state encoding and
// default memory geometry.
package loader_pkg;

  localparam int unsigned LOADER_ADDR_WIDTH = 4;
  localparam int unsigned LOADER_DATA_WIDTH = 8;
  localparam int unsigned MAX_LEN           = 2 ** LOADER_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_RUN,
    ST_ERR
  } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input handshake plus the instruction memory write port
// driven by the program loader.
interface program_loader_if
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = LOADER_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = LOADER_DATA_WIDTH
) ();

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Stream source / memory observer side
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/program_loader.sv
// Receives a framed image (length, payload, checksum), writes the payload into
// instruction memory and releases the CPU once the checksum verifies.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = LOADER_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = LOADER_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  program_loader_if.slave  bus,
  input  logic             cpu_halt,
  output logic             cpu_run,
  output logic             load_done,
  output logic             load_err
);

  localparam int unsigned         MaxLen = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] IdxOne = (ADDR_WIDTH + 1)'(1);

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  fire;
  logic                  len_ok;
  logic [ADDR_WIDTH:0]   idx_inc;

  assign bus.in_ready  = (state_q != ST_RUN);
  assign fire          = bus.in_valid & bus.in_ready;
  assign cpu_run       = (state_q == ST_RUN);
  assign load_done     = done_q;
  assign load_err      = err_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Counters are one bit wider than the address so a full-depth image ends cleanly.
  assign len_ok  = (bus.in_data != '0) && (32'(bus.in_data) <= MaxLen);
  assign idx_inc = idx_q + IdxOne;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      ST_LEN, ST_ERR: begin
        if (fire) begin
          if (len_ok) begin
            len_d   = (ADDR_WIDTH + 1)'(bus.in_data);
            idx_d   = '0;
            csum_d  = '0;
            err_d   = 1'b0;
            state_d = ST_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
      end

      ST_DATA: begin
        if (fire) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q[ADDR_WIDTH-1:0];
          mem_wdata_d = bus.in_data;
          csum_d      = csum_q + bus.in_data;
          idx_d       = idx_inc;
          if (idx_inc == len_q) begin
            state_d = ST_CHK;
          end
        end
      end

      ST_CHK: begin
        if (fire) begin
          if (bus.in_data == csum_q) begin
            done_d  = 1'b1;
            state_d = ST_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
      end

      ST_RUN: begin
        if (cpu_halt) begin
          state_d = ST_LEN;
        end
      end

      default: state_d = ST_LEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LEN;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule
